// File: rtl/radon_axil_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS RW control words, NUM_STATUS RO status words,
// byte strobes, SLVERR decode, self-clearing START. Define RADON_REGBANK_IRQ_EN for the IRQ register.
module radon_axil_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_REGS           = 16,
    parameter int NUM_STATUS         = 4
) (
    input  logic                                 ACLK,
    input  logic                                 ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   ctrl_out,
    output logic                                 start_pulse,
    input  logic [NUM_STATUS*C_S_AXI_DATA_WIDTH-1:0] status_in,
    input  logic                                 done_in,
    output logic                                 irq
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = $clog2(DW / 8);
    localparam int IDX_W    = AW - ADDR_LSB;

    localparam logic [IDX_W-1:0] IDX_IRQ = IDX_W'(NUM_REGS + NUM_STATUS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_WAITD = 2'd1;
    localparam logic [1:0] W_WAITA = 2'd2;
    localparam logic [1:0] W_RESP  = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [1:0]       r_wstate;
    logic [1:0]       w_wstate_nxt;
    logic             r_awready;
    logic             r_wready;
    logic             r_bvalid;
    logic [1:0]       r_bresp;
    logic [IDX_W-1:0] r_awidx;
    logic [DW-1:0]    r_wdata;
    logic [SW-1:0]    r_wstrb;

    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_commit;
    logic [IDX_W-1:0] w_wr_idx;
    logic [DW-1:0]    w_wr_data;
    logic [SW-1:0]    w_wr_strb;
    logic             w_wr_rw;
    logic             w_wr_ok;

    logic [DW-1:0]    r_regs [NUM_REGS];
    logic             r_start;

    logic [0:0]       r_rstate;
    logic             r_arready;
    logic             r_rvalid;
    logic [DW-1:0]    r_rdata;
    logic [1:0]       r_rresp;
    logic             w_ar_hs;
    logic [IDX_W-1:0] w_rd_idx;
    logic [DW-1:0]    w_rd_data;
    logic             w_rd_err;

`ifdef RADON_REGBANK_IRQ_EN
    logic             r_irq_pend;
    logic             r_irq_ena;
    logic             r_irq;
    logic             w_irq_wr;
`endif

    assign w_aw_hs = S_AXI_AWVALID & r_awready;
    assign w_w_hs  = S_AXI_WVALID & r_wready;

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_commit     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end else if (w_aw_hs) begin
                    w_wstate_nxt = W_WAITD;
                end else if (w_w_hs) begin
                    w_wstate_nxt = W_WAITA;
                end
            end
            W_WAITD: begin
                if (w_w_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end
            end
            W_WAITA: begin
                if (w_aw_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end
            end
            W_RESP: begin
                if (r_bvalid && S_AXI_BREADY) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Whichever half arrived first is taken from its holding register, the other live.
    assign w_wr_idx  = (r_wstate == W_WAITD) ? r_awidx : S_AXI_AWADDR[AW-1:ADDR_LSB];
    assign w_wr_data = (r_wstate == W_WAITA) ? r_wdata : S_AXI_WDATA;
    assign w_wr_strb = (r_wstate == W_WAITA) ? r_wstrb : S_AXI_WSTRB;
    assign w_wr_rw   = (w_wr_idx < IDX_W'(NUM_REGS));

`ifdef RADON_REGBANK_IRQ_EN
    assign w_wr_ok = w_wr_rw | (w_wr_idx == IDX_IRQ);
`else
    assign w_wr_ok = w_wr_rw;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_WAITA);
            r_wready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_WAITD);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) begin
                r_awidx <= S_AXI_AWADDR[AW-1:ADDR_LSB];
            end
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // NOTE: the register array is reset because software expects all-zero control words after reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
            r_start <= 1'b0;
        end else begin
            r_start <= w_commit && (w_wr_idx == '0) && w_wr_strb[0] && w_wr_data[0];
            if (w_commit && w_wr_rw) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (w_wr_idx == IDX_W'(k)) begin
                        for (int b = 0; b < SW; b++) begin
                            if (w_wr_strb[b]) begin
                                r_regs[k][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                            end
                        end
                    end
                end
            end
            // START never holds state; it only produces start_pulse.
            r_regs[0][0] <= 1'b0;
        end
    end

    assign w_ar_hs  = S_AXI_ARVALID & r_arready;
    assign w_rd_idx = S_AXI_ARADDR[AW-1:ADDR_LSB];

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b1;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_rd_idx == IDX_W'(k)) begin
                w_rd_data = r_regs[k];
                w_rd_err  = 1'b0;
            end
        end
        for (int k = 0; k < NUM_STATUS; k++) begin
            if (w_rd_idx == IDX_W'(NUM_REGS + k)) begin
                w_rd_data = status_in[k*DW +: DW];
                w_rd_err  = 1'b0;
            end
        end
`ifdef RADON_REGBANK_IRQ_EN
        if (w_rd_idx == IDX_IRQ) begin
            w_rd_data = {{(DW-2){1'b0}}, r_irq_ena, r_irq_pend};
            w_rd_err  = 1'b0;
        end
`endif
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else if (r_rstate == R_IDLE) begin
            if (w_ar_hs) begin
                r_rstate  <= R_DATA;
                r_arready <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rdata   <= w_rd_data;
                r_rresp   <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                r_arready <= 1'b1;
            end
        end else if (S_AXI_RREADY) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
        end
    end

`ifdef RADON_REGBANK_IRQ_EN
    assign w_irq_wr = w_commit && (w_wr_idx == IDX_IRQ) && w_wr_strb[0];

    // A done_in pulse in the same cycle as a W1C keeps PEND set.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_irq_pend <= 1'b0;
            r_irq_ena  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (done_in) begin
                r_irq_pend <= 1'b1;
            end else if (w_irq_wr && w_wr_data[0]) begin
                r_irq_pend <= 1'b0;
            end
            if (w_irq_wr) begin
                r_irq_ena <= w_wr_data[1];
            end
            r_irq <= r_irq_pend & r_irq_ena;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_ctrl
            assign ctrl_out[g*DW +: DW] = r_regs[g];
        end
    endgenerate

    assign start_pulse   = r_start;
    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

    logic w_unused;
`ifdef RADON_REGBANK_IRQ_EN
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
`else
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, done_in,
                        S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
`endif

endmodule

// File: tb/tb_radon_axil_regbank.sv
// Directed self-checking bench for radon_axil_regbank at default parameters (DW=32, AW=8).
// The IRQ section follows RADON_REGBANK_IRQ_EN the same way the design does.
module tb_radon_axil_regbank;

    logic         clk = 1'b0;
    logic         areset;
    logic [7:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [7:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [511:0] ctrl_out;
    logic         start_pulse;
    logic [127:0] status_in;
    logic         done_in;
    logic         irq;

    int n_checks = 0;
    int n_fail   = 0;

    radon_axil_regbank dut (
        .ACLK          (clk),
        .ARESET        (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .ctrl_out      (ctrl_out),
        .start_pulse   (start_pulse),
        .status_in     (status_in),
        .done_in       (done_in),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives AW and W with independent start delays; counts BVALID beats and start pulses.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output int n_b, output int n_pulse);
        bit aw_fire = 0;
        bit w_fire  = 0;
        bit aw_done = 0;
        bit w_done  = 0;
        int post    = 0;
        resp    = 2'b11;
        n_b     = 0;
        n_pulse = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1; aw_fire = 0; end
            if (w_fire)  begin wvalid  = 1'b0; w_done  = 1; w_fire  = 0; end
            if (bvalid) begin n_b++; resp = bresp; end
            if (start_pulse) n_pulse++;
            if (n_b > 0) begin
                post++;
                if (post > 3) break;
            end
            if (!aw_done && !awvalid && cyc >= aw_dly) begin awaddr = addr; awvalid = 1'b1; end
            if (!w_done && !wvalid && cyc >= w_dly) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        int fire_cyc = -1;
        data = 32'hDEAD_DEAD;
        resp = 2'b11;
        lat  = -1;
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (fire_cyc < 0 && arvalid && arready) fire_cyc = cyc;
            @(negedge clk);
            if (fire_cyc >= 0) arvalid = 1'b0;
            if (rvalid) begin
                data = rdata;
                resp = rresp;
                lat  = cyc + 1 - fire_cyc;
                break;
            end
        end
        arvalid = 1'b0;
    endtask

    logic [1:0]  resp;
    logic [31:0] data;
    int          n_b;
    int          n_pulse;
    int          lat;
    int          cnt;

    initial begin
        areset    = 1'b1;
        awaddr    = '0;
        awprot    = '0;
        awvalid   = 1'b0;
        wdata     = '0;
        wstrb     = '0;
        wvalid    = 1'b0;
        bready    = 1'b1;
        araddr    = '0;
        arprot    = '0;
        arvalid   = 1'b0;
        rready    = 1'b1;
        done_in   = 1'b0;
        status_in = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};

        repeat (3) @(negedge clk);
        check("rst_awready", 32'(awready), 32'h0);
        check("rst_wready", 32'(wready), 32'h0);
        check("rst_arready", 32'(arready), 32'h0);
        check("rst_bvalid", 32'(bvalid), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_resp", 32'({bresp, rresp}), 32'h0);
        check("rst_ctrl", 32'(|ctrl_out), 32'h0);
        check("rst_start", 32'(start_pulse), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        areset = 1'b0;

        // Fill reg0..15 with 1..16; reg0's value 1 is only START, so it fires and reads 0.
        for (int k = 0; k < 16; k++) begin
            axi_write(8'(k * 4), 32'(k + 1), 4'hF, 0, 0, resp, n_b, n_pulse);
            check($sformatf("fill_bresp_%0d", k), 32'(resp), 32'h0);
            check($sformatf("fill_pulse_%0d", k), 32'(n_pulse), (k == 0) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 16; k++) begin
            axi_read(8'(k * 4), data, resp, lat);
            check($sformatf("fill_rd_%0d", k), data, (k == 0) ? 32'h0 : 32'(k + 1));
            check($sformatf("fill_rresp_%0d", k), 32'(resp), 32'h0);
        end
        check("rd_latency", 32'(lat), 32'd1);
        check("ctrl_out_reg15", ctrl_out[15*32 +: 32], 32'h10);

        axi_write(8'h0C, 32'hAABB_CCDD, 4'hF, 0, 0, resp, n_b, n_pulse);
        axi_write(8'h0C, 32'h1122_3344, 4'h5, 0, 0, resp, n_b, n_pulse);
        axi_read(8'h0C, data, resp, lat);
        check("strobe_rd", data, 32'hAA22_CC44);
        check("strobe_ctrl", ctrl_out[3*32 +: 32], 32'hAA22_CC44);

        axi_write(8'h1C, 32'hDEAD_BEEF, 4'hF, 0, 3, resp, n_b, n_pulse);
        check("aw_first_nb", 32'(n_b), 32'd1);
        check("aw_first_bresp", 32'(resp), 32'h0);
        axi_read(8'h1C, data, resp, lat);
        check("aw_first_rd", data, 32'hDEAD_BEEF);
        axi_write(8'h20, 32'h1234_5678, 4'hF, 3, 0, resp, n_b, n_pulse);
        check("w_first_nb", 32'(n_b), 32'd1);
        check("w_first_bresp", 32'(resp), 32'h0);
        axi_read(8'h20, data, resp, lat);
        check("w_first_rd", data, 32'h1234_5678);

        axi_write(8'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, n_b, n_pulse);
        check("wr_status_bresp", 32'(resp), 32'h2);
        check("wr_status_nb", 32'(n_b), 32'd1);
        axi_read(8'h40, data, resp, lat);
        check("rd_status0", data, 32'hA0A0_A0A0);
        check("rd_status0_rresp", 32'(resp), 32'h0);
        axi_read(8'h4C, data, resp, lat);
        check("rd_status3", data, 32'hD3D3_D3D3);
        axi_write(8'h7C, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, n_b, n_pulse);
        check("wr_unmapped_bresp", 32'(resp), 32'h2);
        axi_read(8'h7C, data, resp, lat);
        check("rd_unmapped_data", data, 32'h0);
        check("rd_unmapped_rresp", 32'(resp), 32'h2);
        check("nochg_reg3", ctrl_out[3*32 +: 32], 32'hAA22_CC44);
        check("nochg_reg7", ctrl_out[7*32 +: 32], 32'hDEAD_BEEF);
        check("nochg_reg15", ctrl_out[15*32 +: 32], 32'h10);

        axi_write(8'h00, 32'h3, 4'hF, 0, 0, resp, n_b, n_pulse);
        check("start_pulse_cnt", 32'(n_pulse), 32'd1);
        axi_read(8'h00, data, resp, lat);
        check("start_reg0", data, 32'h2);
        axi_write(8'h00, 32'hFF, 4'hE, 0, 0, resp, n_b, n_pulse);
        check("start_nostrb_cnt", 32'(n_pulse), 32'd0);
        axi_read(8'h00, data, resp, lat);
        check("start_nostrb_reg0", data, 32'h2);

        axi_read(8'h0F, data, resp, lat);
        check("lowbits_rd", data, 32'hAA22_CC44);
        axi_write(8'h25, 32'h99, 4'hF, 0, 0, resp, n_b, n_pulse);
        axi_read(8'h24, data, resp, lat);
        check("lowbits_wr", data, 32'h99);

        // Write commit and AR to reg5 on the same edge: the read sees the old value 6.
        @(negedge clk);
        awaddr = 8'h14; wdata = 32'h66; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h14; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("samecyc_rvalid", 32'(rvalid), 32'h1);
        check("samecyc_rdata", rdata, 32'h6);
        check("samecyc_bvalid", 32'(bvalid), 32'h1);
        axi_read(8'h14, data, resp, lat);
        check("samecyc_after", data, 32'h66);

`ifdef RADON_REGBANK_IRQ_EN
        axi_write(8'h50, 32'h2, 4'hF, 0, 0, resp, n_b, n_pulse);
        check("irq_ena_bresp", 32'(resp), 32'h0);
        @(negedge clk); done_in = 1'b1;
        @(negedge clk); done_in = 1'b0;
        repeat (3) @(negedge clk);
        check("irq_set", 32'(irq), 32'h1);
        axi_read(8'h50, data, resp, lat);
        check("irq_reg_set", data, 32'h3);
        axi_write(8'h50, 32'h3, 4'hF, 0, 0, resp, n_b, n_pulse);
        repeat (2) @(negedge clk);
        check("irq_w1c", 32'(irq), 32'h0);
        axi_read(8'h50, data, resp, lat);
        check("irq_reg_w1c", data, 32'h2);
        @(negedge clk);
        awaddr = 8'h50; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; done_in = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; done_in = 1'b0;
        repeat (3) @(negedge clk);
        check("irq_set_wins", 32'(irq), 32'h1);
`else
        axi_write(8'h50, 32'h2, 4'hF, 0, 0, resp, n_b, n_pulse);
        check("irq_idx_bresp", 32'(resp), 32'h2);
        axi_read(8'h50, data, resp, lat);
        check("irq_idx_rdata", data, 32'h0);
        check("irq_idx_rresp", 32'(resp), 32'h2);
        @(negedge clk); done_in = 1'b1;
        @(negedge clk); done_in = 1'b0;
        repeat (3) @(negedge clk);
        check("irq_tied", 32'(irq), 32'h0);
`endif

        // Reset while a write is waiting for data: it is dropped without a response.
        @(negedge clk);
        awaddr = 8'h08; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        areset = 1'b1;
        @(negedge clk);
        check("midrst_awready", 32'(awready), 32'h0);
        check("midrst_bvalid", 32'(bvalid), 32'h0);
        check("midrst_ctrl", 32'(|ctrl_out), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        areset = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bvalid) cnt++;
        end
        check("midrst_no_bresp", 32'(cnt), 32'd0);
        check("midrst_awready_back", 32'(awready), 32'h1);
        axi_read(8'h04, data, resp, lat);
        check("midrst_reg1", data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
